instr_decoder: RTL and testbench
================================

Name: instr_decoder

Overview:
Issue side of the decoder/register-file protocol. Accepts one 32-bit RV32I instruction per valid/ready handshake and decodes R-type ALU, I-type ALU and LUI. Sequences the register file through address latch, optional immediate store, and ALU write-back. Drives ALU control and waits for op_done before accepting the next instruction.

Parameters:
TIMEOUT, 15, max cycles spent in WAIT_DONE without op_done before the err pulse (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instruction offered
instr  in  32  RV32I instruction word
instr_ready  out  1  decoder idle; handshake when valid&&ready
rs_addr_valid  out  1  one-cycle address-latch strobe to regfile
rs1_rs2_rd  out  15  packed {rs1[4:0], rs2[4:0], rd[4:0]}
rs_store  out  1  immediate store, qualified by rs_addr_valid
imme_data  out  32  data for immediate store
rd_wr_en  out  1  one-cycle ALU write-back strobe
op_done  in  1  regfile acknowledge, registered on the regfile side
alu_op  out  4  ALU operation, alu_op_t
alu_src_imm  out  1  1: ALU operand B = alu_imm; 0: regfile rs2 data
alu_imm  out  32  sign-extended I-type immediate
illegal  out  1  one-cycle pulse: unsupported or malformed instruction
err  out  1  one-cycle pulse: op_done timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: state=IDLE; instr register, alu_op, alu_imm and timeout counter cleared. instr_ready=1. All other outputs 0.
- States: IDLE, DECODE, EXEC, WB, WAIT_DONE. All outputs are Moore decodes of the state register and the captured instruction register.
- IDLE: instr_ready=1. On instr_valid, capture instr and go to DECODE. instr_ready is 0 in every other state.
- DECODE, 1 cycle:
  - Illegal instruction: pulse illegal, no regfile strobe, go to IDLE.
  - Legal instruction: rs_addr_valid=1.
  - R-type (opcode 0110011): rs1_rs2_rd={rs1,rs2,rd}.
  - I-type ALU (0010011): rs1_rs2_rd={rs1,5'd0,rd}.
  - LUI (0110111): rs1_rs2_rd={5'd0,5'd0,rd}, rs_store=1, imme_data={instr[31:12],12'h000}, go to WAIT_DONE.
  - ALU types go to EXEC.
- EXEC, 1 cycle: regfile read data is now valid. alu_op, alu_src_imm and alu_imm are stable from DECODE through WB. Go to WB.
- WB, 1 cycle: rd_wr_en=1. Go to WAIT_DONE.
- WAIT_DONE:
  - On op_done, go to IDLE.
  - Counter increments each cycle without op_done. When it reaches TIMEOUT, pulse err and go to IDLE.
  - Counter clears on entry.
- op_done outside WAIT_DONE is ignored.
- rd=x0 is still issued normally; the regfile suppresses the write and still acks.
- Legality rules:
  - R-type: funct7 must be 0000000, or 0100000 with funct3 000 (SUB) or 101 (SRA).
  - I-type: SLLI requires funct7=0000000; SRLI/SRAI require 0000000/0100000.
  - Any other opcode is illegal.
- alu_imm = sign-extend instr[31:20]. For shifts, only bits [4:0] are meaningful to the ALU.
- Latency, handshake edge = cycle 0:
  - LUI: rs_addr_valid cycle 1, op_done cycle 2, instr_ready cycle 3.
  - ALU: rs_addr_valid 1, rd_wr_en 3, op_done 4, instr_ready 5.
  - Illegal: illegal pulse cycle 1, instr_ready cycle 2.
- Reset mid-operation: all outputs are cleared immediately. A lost regfile ack is not replayed.

Decomposition:
- riscv_decode_pkg:
  - opcode constants OP_R, OP_I, OP_LUI
  - funct3/funct7 constants
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - dec_state_t
- One combinational sub-module, dec_field_gen: instruction -> {legal, is_lui, is_imm, alu_op, alu_imm, imme_data, packed addresses}. instr_decoder keeps the FSM and the timeout counter.

Test Plan:
- ADDI x5,x0,7 (0x00700293):
  - cycle 1: rs_addr_valid=1, rs1_rs2_rd=15'h0005, rs_store=0.
  - alu_op=ADD, alu_src_imm=1, alu_imm=7.
  - cycle 3: rd_wr_en=1. With op_done in cycle 4, instr_ready=1 in cycle 5.
- LUI x1,0x12345 (0x123450B7): cycle 1 rs_addr_valid=1, rs_store=1, rs1_rs2_rd=15'h0001, imme_data=0x12345000. op_done in cycle 2 -> instr_ready=1 in cycle 3.
- SUB x3,x1,x2 (0x402081B3): rs1_rs2_rd=15'h0443, alu_op=SUB, alu_src_imm=0. rd_wr_en pulses exactly once, in cycle 3.
- instr 0x00000000 and R-type funct7=0100000 with funct3=001: illegal pulse in cycle 1, no rs_addr_valid or rd_wr_en, instr_ready=1 in cycle 2.
- ADDI with op_done held 0: err pulses exactly after TIMEOUT=15 cycles in WAIT_DONE, then IDLE. A stray op_done while in IDLE causes no state change.
- rst asserted in WB: rd_wr_en and busy drop asynchronously. After release, instr_ready=1 and the next LUI completes normally.

Source files
------------

// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode constants and types for the instruction issue path.
package riscv_decode_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_t;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StWaitDone} dec_state_t;

  typedef struct packed {
    logic        legal;
    logic        is_lui;
    logic        is_imm;
    alu_op_t     alu_op;
    logic [31:0] alu_imm;
    logic [31:0] imme_data;
    logic [14:0] addrs;      // {rs1, rs2, rd}
  } dec_fields_t;

endpackage

// File: rtl/dec_field_gen.sv
// Purely combinational field extraction and legality check for one RV32I word.
module dec_field_gen
  import riscv_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_fields_t fields_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       is_r;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign is_r   = (opcode == OP_R);

  always_comb begin
    fields_o           = '0;
    fields_o.alu_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
    fields_o.imme_data = {instr_i[31:12], 12'h000};
    case (opcode)
      OP_R, OP_I: begin
        fields_o.is_imm = !is_r;
        fields_o.addrs  = {rs1, (is_r ? rs2 : 5'd0), rd};
        case (funct3)
          F3_ADD:  fields_o.alu_op = (is_r && funct7 == F7_ALT) ? AluSub : AluAdd;
          F3_SLL:  fields_o.alu_op = AluSll;
          F3_SLT:  fields_o.alu_op = AluSlt;
          F3_SLTU: fields_o.alu_op = AluSltu;
          F3_XOR:  fields_o.alu_op = AluXor;
          F3_SR:   fields_o.alu_op = (funct7 == F7_ALT) ? AluSra : AluSrl;
          F3_OR:   fields_o.alu_op = AluOr;
          F3_AND:  fields_o.alu_op = AluAnd;
        endcase
        // I-type funct7 is immediate data except for the shift encodings.
        if (is_r) begin
          fields_o.legal = (funct7 == F7_BASE) ||
                           (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
        end else if (funct3 == F3_SLL) begin
          fields_o.legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_SR) begin
          fields_o.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          fields_o.legal = 1'b1;
        end
      end
      OP_LUI: begin
        fields_o.legal  = 1'b1;
        fields_o.is_lui = 1'b1;
        fields_o.addrs  = {10'd0, rd};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Issue-side decoder: handshakes one instruction, sequences the register file and
// waits for its acknowledge (with timeout) before accepting the next.
module instr_decoder
  import riscv_decode_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        rs_addr_valid,
  output logic [14:0] rs1_rs2_rd,
  output logic        rs_store,
  output logic [31:0] imme_data,
  output logic        rd_wr_en,
  input  logic        op_done,
  output alu_op_t     alu_op,
  output logic        alu_src_imm,
  output logic [31:0] alu_imm,
  output logic        illegal,
  output logic        err,
  output logic        busy
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  dec_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  dec_fields_t fields;

  dec_field_gen u_dec_field_gen (
    .instr_i  (instr_q),
    .fields_o (fields)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!fields.legal)      state_d = StIdle;
        else if (fields.is_lui) state_d = StWaitDone;
        else                    state_d = StExec;
      end
      StExec: state_d = StWb;
      StWb:   state_d = StWaitDone;
      StWaitDone: begin
        if (op_done || cnt_q == TimeoutCnt) state_d = StIdle;
        else                                cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_ready   = (state_q == StIdle);
    busy          = (state_q != StIdle);
    rs_addr_valid = (state_q == StDecode) && fields.legal;
    illegal       = (state_q == StDecode) && !fields.legal;
    rs_store      = rs_addr_valid && fields.is_lui;
    rs1_rs2_rd    = rs_addr_valid ? fields.addrs : '0;
    imme_data     = rs_store ? fields.imme_data : '0;
    rd_wr_en      = (state_q == StWb);
    err           = (state_q == StWaitDone) && (cnt_q == TimeoutCnt);
    // ALU controls follow the held instruction, so they stay stable DECODE..WB.
    alu_op        = fields.alu_op;
    alu_src_imm   = fields.is_imm;
    alu_imm       = fields.alu_imm;
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed vector table, reset/stray-ack
// sequences, and random instructions checked against an encoding-table model.
module tb_instr_decoder;
  import riscv_decode_pkg::*;

  localparam int Timeout = 15;
  localparam int KIll = 0, KLui = 1, KAlu = 2;

  typedef struct {
    logic [31:0] instr;
    int          kind;
    logic [14:0] addr;
    logic [31:0] imme;
    alu_op_t     op;
    logic        src;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
    int    ack;   // cycles into WAIT_DONE before op_done; -1 = never
  } vec_t;

  logic        clk, rst, instr_valid, instr_ready, rs_addr_valid, rs_store, rd_wr_en;
  logic        op_done, alu_src_imm, illegal, err, busy;
  logic [31:0] instr, imme_data, alu_imm;
  logic [14:0] rs1_rs2_rd;
  alu_op_t     alu_op;

  int n_pass = 0;
  int n_total = 0;

  // Legal encodings as {funct7, funct3} per op; -1 funct7 means "any immediate".
  logic [9:0] r_enc [10];
  alu_op_t    r_op  [10];
  int         i_f3  [9];
  int         i_f7  [9];
  alu_op_t    i_op  [9];

  instr_decoder #(.TIMEOUT(Timeout)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .rs_addr_valid (rs_addr_valid),
    .rs1_rs2_rd    (rs1_rs2_rd),
    .rs_store      (rs_store),
    .imme_data     (imme_data),
    .rd_wr_en      (rd_wr_en),
    .op_done       (op_done),
    .alu_op        (alu_op),
    .alu_src_imm   (alu_src_imm),
    .alu_imm       (alu_imm),
    .illegal       (illegal),
    .err           (err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] ins, input int kind,
                              input logic [14:0] addr, input logic [31:0] imme,
                              input alu_op_t op, input logic src, input logic [31:0] imm,
                              input int ack);
    vec_t v;
    v.nm = nm; v.ack = ack;
    v.e.instr = ins; v.e.kind = kind; v.e.addr = addr; v.e.imme = imme;
    v.e.op = op; v.e.src = src; v.e.imm = imm;
    return v;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] w);
    exp_t e;
    e.instr = w; e.kind = KIll; e.addr = '0; e.op = AluAdd; e.src = 1'b0;
    e.imme  = {w[31:12], 12'h000};
    e.imm   = 32'($signed(w[31:20]));
    if (w[6:0] == OP_LUI) begin
      e.kind = KLui;
      e.addr = {10'd0, w[11:7]};
    end else if (w[6:0] == OP_R) begin
      for (int i = 0; i < 10; i++)
        if ({w[31:25], w[14:12]} == r_enc[i]) begin
          e.kind = KAlu; e.op = r_op[i];
        end
      e.addr = {w[19:15], w[24:20], w[11:7]};
    end else if (w[6:0] == OP_I) begin
      for (int i = 0; i < 9; i++)
        if (int'(w[14:12]) == i_f3[i] && (i_f7[i] < 0 || int'(w[31:25]) == i_f7[i])) begin
          e.kind = KAlu; e.op = i_op[i];
        end
      e.src  = 1'b1;
      e.addr = {w[19:15], 5'd0, w[11:7]};
    end
    return e;
  endfunction

  // Issue one instruction from idle (called at a negedge) and follow it back to idle.
  task automatic issue(input string nm, input exp_t e, input int ack);
    int wait_start, ack_cyc, ready_cyc, n_rdwr, rdwr_cyc, n_err, err_cyc, n_ill, n_rsav;
    int n_notbusy, exp_ready;
    wait_start = (e.kind == KLui) ? 2 : 4;
    ack_cyc = (ack < 0) ? -1 : wait_start + ack;
    ready_cyc = -1; n_rdwr = 0; rdwr_cyc = -1; n_err = 0; err_cyc = -1;
    n_ill = 0; n_rsav = 0; n_notbusy = 0;
    chk({nm, ".ready0"}, 32'(instr_ready), 32'd1);
    instr = e.instr; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0; instr = $urandom;
    chk({nm, ".illegal1"}, 32'(illegal), 32'(e.kind == KIll));
    chk({nm, ".rsav1"}, 32'(rs_addr_valid), 32'(e.kind != KIll));
    chk({nm, ".ready1"}, 32'(instr_ready), 32'd0);
    if (e.kind != KIll) begin
      chk({nm, ".addr"}, 32'(rs1_rs2_rd), 32'(e.addr));
      chk({nm, ".store"}, 32'(rs_store), 32'(e.kind == KLui));
    end
    if (e.kind == KLui) chk({nm, ".imme"}, imme_data, e.imme);
    if (e.kind == KAlu) begin
      chk({nm, ".op"}, 32'(alu_op), 32'(e.op));
      chk({nm, ".src"}, 32'(alu_src_imm), 32'(e.src));
      chk({nm, ".imm"}, alu_imm, e.imm);
    end
    for (int cyc = 2; cyc < 80; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (instr_ready) begin
        ready_cyc = cyc;
        break;
      end
      if (!busy) n_notbusy++;
      if (rd_wr_en) begin n_rdwr++; rdwr_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (illegal) n_ill++;
      if (rs_addr_valid) n_rsav++;
      if (e.kind == KAlu && cyc == 3) begin
        chk({nm, ".op_wb"}, 32'(alu_op), 32'(e.op));
        chk({nm, ".imm_wb"}, alu_imm, e.imm);
      end
      op_done = (cyc == ack_cyc);
    end
    op_done = 1'b0;
    if (e.kind == KIll)  exp_ready = 2;
    else if (ack >= 0)   exp_ready = wait_start + ack + 1;
    else                 exp_ready = wait_start + Timeout + 1;
    chk({nm, ".ready_cyc"}, 32'(ready_cyc), 32'(exp_ready));
    chk({nm, ".n_rdwr"}, 32'(n_rdwr), 32'(e.kind == KAlu));
    if (e.kind == KAlu) chk({nm, ".rdwr_cyc"}, 32'(rdwr_cyc), 32'd3);
    chk({nm, ".n_err"}, 32'(n_err), 32'(e.kind != KIll && ack < 0));
    if (e.kind != KIll && ack < 0)
      chk({nm, ".err_cyc"}, 32'(err_cyc), 32'(wait_start + Timeout));
    chk({nm, ".late_strobes"}, 32'(n_ill + n_rsav + n_notbusy), 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    r_enc = '{{F7_BASE, F3_ADD}, {F7_ALT, F3_ADD}, {F7_BASE, F3_SLL}, {F7_BASE, F3_SLT},
              {F7_BASE, F3_SLTU}, {F7_BASE, F3_XOR}, {F7_BASE, F3_SR}, {F7_ALT, F3_SR},
              {F7_BASE, F3_OR}, {F7_BASE, F3_AND}};
    r_op  = '{AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd};
    i_f3  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    i_f7  = '{-1, -1, -1, -1, -1, -1, 0, 0, 32};
    i_op  = '{AluAdd, AluSlt, AluSltu, AluXor, AluOr, AluAnd, AluSll, AluSrl, AluSra};

    vecs[0]  = mk("addi",    32'h00700293, KAlu, 15'h0005, 0, AluAdd,  1'b1, 32'h7, 0);
    vecs[1]  = mk("lui",     32'h123450B7, KLui, 15'h0001, 32'h12345000, AluAdd, 0, 0, 0);
    vecs[2]  = mk("sub",     32'h402081B3, KAlu, 15'h0443, 0, AluSub,  1'b0, 32'h402, 0);
    vecs[3]  = mk("zero",    32'h00000000, KIll, 0, 0, AluAdd, 0, 0, 0);
    vecs[4]  = mk("r_alt1",  32'h40001033, KIll, 0, 0, AluAdd, 0, 0, 0);
    vecs[5]  = mk("srai",    32'h40335393, KAlu, 15'h1807, 0, AluSra,  1'b1, 32'h403, 2);
    vecs[6]  = mk("slli_bad",32'h40001013, KIll, 0, 0, AluAdd, 0, 0, 0);
    vecs[7]  = mk("andi",    32'hFFF0F113, KAlu, 15'h0402, 0, AluAnd,  1'b1, 32'hFFFFFFFF, 5);
    vecs[8]  = mk("addi_to", 32'h00700293, KAlu, 15'h0005, 0, AluAdd,  1'b1, 32'h7, -1);
    vecs[9]  = mk("lui31",   32'hFFFFFFB7, KLui, 15'h001F, 32'hFFFFF000, AluAdd, 0, 0, 3);
    vecs[10] = mk("sltu",    32'h00C5B533, KAlu, 15'h2D8A, 0, AluSltu, 1'b0, 32'hC, 1);
    vecs[11] = mk("mul",     32'h02208133, KIll, 0, 0, AluAdd, 0, 0, 0);

    instr_valid = 1'b0; instr = '0; op_done = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst.ready", 32'(instr_ready), 32'd1);
    chk("rst.outs", 32'({busy, rs_addr_valid, rs_store, rd_wr_en, illegal, err, alu_src_imm}),
        32'd0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    chk("rst.alu_imm", alu_imm, 32'd0);
    chk("rst.data", imme_data | 32'(rs1_rs2_rd), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) issue(vecs[i].nm, vecs[i].e, vecs[i].ack);

    // Stray acknowledge while idle must be ignored.
    op_done = 1'b1;
    @(negedge clk); op_done = 1'b0;
    chk("stray.ready", 32'(instr_ready), 32'd1);
    chk("stray.busy_err", 32'({busy, err}), 32'd0);
    @(negedge clk);
    chk("stray.ready2", 32'(instr_ready), 32'd1);

    // Reset in WB drops the strobe immediately; next instruction runs normally.
    instr = 32'h00700293; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk); instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("wbrst.rdwr_before", 32'(rd_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("wbrst.rdwr", 32'(rd_wr_en), 32'd0);
    chk("wbrst.busy", 32'(busy), 32'd0);
    chk("wbrst.ready", 32'(instr_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue("post_rst_lui", vecs[1].e, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] w;
      int sel, ack;
      w = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4)       w[6:0] = OP_R;
      else if (sel < 8)  w[6:0] = OP_I;
      else if (sel == 8) w[6:0] = OP_LUI;
      sel = $urandom_range(0, 3);
      if (sel < 2)       w[31:25] = F7_BASE;
      else if (sel == 2) w[31:25] = F7_ALT;
      ack = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
      issue($sformatf("rand%0d_%08h", n, w), ref_model(w), ack);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
